pipeline_exec_ctrl: RTL and testbench
=====================================

Name: pipeline_exec_ctrl

Overview:
- Execution controller for the 5-stage pipeline.
- Produces the global step enable that gates every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB), plus the per-stage write and flush qualifiers.
- Arbitrates between debug-unit commands (run, single-step, stop), hazard requests (load-use stall, taken-branch flush) and HALT-instruction drain.
- Sits between the debug unit and the datapath. Clocked on posedge; pipeline registers sample its outputs on negedge.

Parameters:
- NB, 32, width of the executed-cycle counter.
- PIPE_DEPTH, 5, number of stages; the drain length after a HALT is fetched.
- NB_DRAIN, 3, width of the drain counter; must satisfy 2^NB_DRAIN > PIPE_DEPTH.

Ports:
- i_clk  in  1  system clock, posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_run  in  1  one-cycle pulse: enter continuous run.
- i_cmd_step  in  1  one-cycle pulse: execute exactly one pipeline cycle.
- i_cmd_stop  in  1  one-cycle pulse: pause continuous run.
- i_halt_fetched  in  1  instruction currently being fetched is HALT.
- i_load_use_hazard  in  1  ID-stage load-use detection.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- o_step  out  1  global enable to all pipeline registers.
- o_pc_write  out  1  PC update enable.
- o_if_id_write  out  1  IF_ID load enable.
- o_if_id_flush  out  1  load bubble into IF_ID.
- o_id_ex_flush  out  1  load bubble into ID_EX.
- o_halted  out  1  program finished.
- o_step_done  out  1  one-cycle pulse after a single step completes.
- o_state  out  3  current FSM state, for debug readout.
- o_cycle_count  out  NB  executed (o_step=1) cycles.

Behaviour:
- Reset: state IDLE; o_step, o_pc_write, o_if_id_write, flushes, o_halted, o_step_done = 0; o_cycle_count = 0; drain counter = 0.
- FSM registered on posedge. o_step and the qualifiers are combinational from the registered state plus hazard inputs. They are stable by the following negedge.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE:
  - o_step=0.
  - i_cmd_run -> RUN; else i_cmd_step -> STEP. Run wins if both are asserted.
  - i_cmd_stop is ignored.
- RUN:
  - o_step=1 every cycle.
  - i_halt_fetched -> DRAIN, loading the drain counter with PIPE_DEPTH-1.
  - Otherwise i_cmd_stop -> IDLE. HALT beats stop in the same cycle.
  - i_cmd_run and i_cmd_step are ignored.
- STEP:
  - o_step=1 for exactly one cycle.
  - Next state: DRAIN if i_halt_fetched, else IDLE.
  - o_step_done=1 in the cycle after STEP when returning to IDLE (registered pulse).
  - All commands are ignored.
- DRAIN:
  - o_step=1, o_pc_write=0, o_if_id_write=1, o_if_id_flush=1, o_id_ex_flush=0.
  - Effect: the HALT advances while bubbles follow it.
  - Counter decrements each cycle. When the counter is 0 -> HALTED.
  - Commands and hazards are ignored.
  - Total DRAIN cycles = PIPE_DEPTH.
- HALTED:
  - o_step=0, o_halted=1.
  - Exit only via i_reset.
- Qualifiers in RUN/STEP:
  - Default: pc_write=1, if_id_write=1, flushes=0.
  - i_load_use_hazard: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
  - Else i_branch_taken: if_id_flush=1.
  - Load-use has priority; the branch is re-resolved next cycle.
- Whenever o_step=0, all qualifiers are 0.
- o_cycle_count increments each cycle o_step=1, including DRAIN. It saturates at all-ones.
- Reset mid-RUN or mid-DRAIN: returns to IDLE next cycle with all reset values. A pending drain is discarded.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - state encodings;
  - PIPE_DEPTH default;
  - HALT opcode constant (used by the IF-stage decoder that drives i_halt_fetched).
- One sub-module, sat_counter: parameterised-width saturating up-counter with enable and synchronous reset. It is used for o_cycle_count.

Test Plan:
1. Reset, then i_cmd_step pulse -> o_step=1 for exactly 1 cycle; o_step_done=1 the next cycle; o_cycle_count=1; state back to 0.
2. i_cmd_run, wait 10 cycles, then i_cmd_stop -> o_step high for 10 cycles (run sampled at cycle 0 gives o_step cycles 1..10); o_cycle_count=10; state=IDLE.
3. RUN with i_load_use_hazard high for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1. Same cycle with i_branch_taken also high -> if_id_flush stays 0.
4. RUN, i_halt_fetched at cycle k -> DRAIN for 5 cycles with pc_write=0, if_id_flush=1; o_halted=1 from cycle k+6; further i_cmd_run has no effect.
5. i_halt_fetched and i_cmd_stop same cycle in RUN -> DRAIN, not IDLE. i_reset during DRAIN -> IDLE next cycle, o_cycle_count=0, o_halted=0.
6. Force o_cycle_count near saturation (NB=4 instance), run 20 cycles -> count holds at 15.

Source files
------------

// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared definitions for the pipeline execution controller: state encodings,
// pipeline depth default, HALT opcode and the hazard qualifier helper.
package pipeline_ctrl_pkg;

    localparam int          PIPE_DEPTH_DEFAULT = 5;
    localparam logic [31:0] HALT_OPCODE        = 32'hFC00_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } qual_t;

    // Load-use freezes PC/IF_ID and bubbles ID_EX; the branch waits until the stall clears.
    function automatic qual_t hazard_qual(input logic load_use, input logic branch_taken);
        qual_t q;
        q.pc_write    = !load_use;
        q.if_id_write = !load_use;
        q.id_ex_flush = load_use;
        q.if_id_flush = !load_use && branch_taken;
        return q;
    endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Command/hazard inputs and step/qualifier outputs of the execution controller.
interface pipeline_exec_ctrl_if #(parameter int NB = 32);

    logic          i_cmd_run;
    logic          i_cmd_step;
    logic          i_cmd_stop;
    logic          i_halt_fetched;
    logic          i_load_use_hazard;
    logic          i_branch_taken;
    logic          o_step;
    logic          o_pc_write;
    logic          o_if_id_write;
    logic          o_if_id_flush;
    logic          o_id_ex_flush;
    logic          o_halted;
    logic          o_step_done;
    logic [2:0]    o_state;
    logic [NB-1:0] o_cycle_count;

    modport master (
        output i_cmd_run, i_cmd_step, i_cmd_stop, i_halt_fetched,
               i_load_use_hazard, i_branch_taken,
        input  o_step, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
               o_halted, o_step_done, o_state, o_cycle_count
    );

    modport slave (
        input  i_cmd_run, i_cmd_step, i_cmd_stop, i_halt_fetched,
               i_load_use_hazard, i_branch_taken,
        output o_step, o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
               o_halted, o_step_done, o_state, o_cycle_count
    );

endinterface

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Parameterised-width up-counter with enable that holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_count <= '0;
        else if (i_en && (r_count != '1))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: arbitrates debug commands, hazards and HALT drain into
// the global pipeline step enable and per-stage write/flush qualifiers.
module pipeline_exec_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB         = 32,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT,
    parameter int NB_DRAIN   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pipeline_exec_ctrl_if.slave  bus
);

    state_e              r_state;
    state_e              w_next;
    logic [NB_DRAIN-1:0] r_drain;
    logic                r_step_done;
    logic                w_load_drain;
    logic                w_step;
    qual_t               w_qual;
    logic [NB-1:0]       w_count;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_load_drain = 1'b0;
        w_step       = 1'b0;
        w_qual       = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_cmd_run)
                    w_next = ST_RUN;
                else if (bus.i_cmd_step)
                    w_next = ST_STEP;
            end
            ST_RUN: begin
                w_step = 1'b1;
                w_qual = hazard_qual(bus.i_load_use_hazard, bus.i_branch_taken);
                if (bus.i_halt_fetched) begin
                    w_next       = ST_DRAIN;
                    w_load_drain = 1'b1;
                end else if (bus.i_cmd_stop) begin
                    w_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_step = 1'b1;
                w_qual = hazard_qual(bus.i_load_use_hazard, bus.i_branch_taken);
                if (bus.i_halt_fetched) begin
                    w_next       = ST_DRAIN;
                    w_load_drain = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // PC frozen on the HALT; bubbles enter IF_ID behind it.
                w_step = 1'b1;
                w_qual = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b0};
                if (r_drain == '0)
                    w_next = ST_HALTED;
            end
            ST_HALTED: begin
                w_next = ST_HALTED;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Loaded with PIPE_DEPTH-1 so the drain covers PIPE_DEPTH cycles including the zero count.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_drain <= '0;
        else if (w_load_drain)
            r_drain <= NB_DRAIN'(PIPE_DEPTH - 1);
        else if ((r_state == ST_DRAIN) && (r_drain != '0))
            r_drain <= r_drain - NB_DRAIN'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_step_done <= 1'b0;
        else
            r_step_done <= (r_state == ST_STEP) && (w_next == ST_IDLE);
    end

    sat_counter #(.W(NB)) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_step),
        .o_count (w_count)
    );

    assign bus.o_step        = w_step;
    assign bus.o_pc_write    = w_qual.pc_write;
    assign bus.o_if_id_write = w_qual.if_id_write;
    assign bus.o_if_id_flush = w_qual.if_id_flush;
    assign bus.o_id_ex_flush = w_qual.id_ex_flush;
    assign bus.o_halted      = (r_state == ST_HALTED);
    assign bus.o_step_done   = r_step_done;
    assign bus.o_state       = r_state;
    assign bus.o_cycle_count = w_count;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Randomised bench for pipeline_exec_ctrl against a cycle-level behavioural model;
// a second NB=4 instance shares the stimulus to exercise counter saturation.
module tb_pipeline_exec_ctrl;

    localparam int DEPTH = 5;

    logic i_clk;
    logic i_reset;

    pipeline_exec_ctrl_if #(.NB(32)) bus ();
    pipeline_exec_ctrl_if #(.NB(4))  bus4 ();

    pipeline_exec_ctrl #(.NB(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    pipeline_exec_ctrl #(.NB(4)) dut4 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus4)
    );

    assign bus4.i_cmd_run         = bus.i_cmd_run;
    assign bus4.i_cmd_step        = bus.i_cmd_step;
    assign bus4.i_cmd_stop        = bus.i_cmd_stop;
    assign bus4.i_halt_fetched    = bus.i_halt_fetched;
    assign bus4.i_load_use_hazard = bus.i_load_use_hazard;
    assign bus4.i_branch_taken    = bus.i_branch_taken;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: mode numbers are the architectural state codes, m_left counts remaining drain cycles.
    int     m_mode  = 0;
    int     m_left  = 0;
    longint m_count = 0;
    bit     m_done  = 0;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [45:0] exp_vec();
        logic st;
        logic [3:0] q;
        st = (m_mode >= 1) && (m_mode <= 3);
        q  = 4'b0000;
        if (m_mode == 1 || m_mode == 2) begin
            if (bus.i_load_use_hazard) q = 4'b0001;
            else                       q = {2'b11, bus.i_branch_taken, 1'b0};
        end else if (m_mode == 3) begin
            q = 4'b0110;
        end
        return {st, q, (m_mode == 4), m_done, 3'(m_mode),
                32'(sat(m_count, 32)), 4'(sat(m_count, 4))};
    endfunction

    function automatic logic [45:0] obs_vec();
        return {bus.o_step, bus.o_pc_write, bus.o_if_id_write, bus.o_if_id_flush,
                bus.o_id_ex_flush, bus.o_halted, bus.o_step_done, bus.o_state,
                bus.o_cycle_count, bus4.o_cycle_count};
    endfunction

    task automatic apply(input logic rst, input logic run, input logic stp, input logic stop,
                         input logic halt, input logic lu, input logic br);
        i_reset               = rst;
        bus.i_cmd_run         = run;
        bus.i_cmd_step        = stp;
        bus.i_cmd_stop        = stop;
        bus.i_halt_fetched    = halt;
        bus.i_load_use_hazard = lu;
        bus.i_branch_taken    = br;
        @(negedge i_clk);
    endtask

    task automatic advance();
        @(posedge i_clk);
        if (i_reset) begin
            m_mode = 0; m_left = 0; m_count = 0; m_done = 0;
        end else begin
            if (m_mode >= 1 && m_mode <= 3) m_count++;
            m_done = (m_mode == 2) && !bus.i_halt_fetched;
            case (m_mode)
                0: if (bus.i_cmd_run) m_mode = 1; else if (bus.i_cmd_step) m_mode = 2;
                1: if (bus.i_halt_fetched) begin m_mode = 3; m_left = DEPTH; end
                   else if (bus.i_cmd_stop) m_mode = 0;
                2: if (bus.i_halt_fetched) begin m_mode = 3; m_left = DEPTH; end
                   else m_mode = 0;
                3: begin m_left--; if (m_left == 0) m_mode = 4; end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        logic [45:0] o, e;
        apply(1, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(i == 0, 0, 0, 1, 1, 1, 1);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
    endtask

    task automatic test_single_step();
        logic [45:0] o, e;
        int steps;
        steps = 0;
        for (int i = 0; i < 6; i++) begin
            apply(i == 0, 0, i == 1, 0, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL single_step cyc=%0d got=%h exp=%h", i, o, e); end
            if (bus.o_step === 1'b1) steps++;
            advance();
        end
        n_vec++;
        if (steps != 1 || bus.o_cycle_count !== 32'd1 || bus.o_state !== 3'd0) begin
            n_bad++;
            $display("FAIL single_step_total steps=%0d count=%0d state=%0d need 1/1/0",
                     steps, bus.o_cycle_count, bus.o_state);
        end
    endtask

    task automatic test_run_stop();
        logic [45:0] o, e;
        for (int i = 0; i < 14; i++) begin
            apply(i == 0, i == 1, 0, i == 11, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL run_stop cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
        n_vec++;
        if (bus.o_cycle_count !== 32'd10 || bus.o_state !== 3'd0) begin
            n_bad++;
            $display("FAIL run_stop_total count=%0d state=%0d need 10/0", bus.o_cycle_count, bus.o_state);
        end
    endtask

    task automatic test_hazards();
        logic [45:0] o, e;
        for (int i = 0; i < 40; i++) begin
            apply(i == 0, i == 1, 0, i == 38, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 5) begin
                bus.i_load_use_hazard = 1'b1;
                bus.i_branch_taken    = 1'b1;
                #1;
                n_vec++;
                if (bus.o_if_id_flush !== 1'b0 || bus.o_id_ex_flush !== 1'b1 || bus.o_pc_write !== 1'b0) begin
                    n_bad++;
                    $display("FAIL load_use_priority iff=%b idf=%b pc=%b need 0/1/0",
                             bus.o_if_id_flush, bus.o_id_ex_flush, bus.o_pc_write);
                end
            end
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL hazards cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
    endtask

    task automatic test_halt_drain();
        logic [45:0] o, e;
        int k;
        k = 2 + $urandom_range(0, 6);
        for (int i = 0; i < k + 16; i++) begin
            if (i <= k + 1)
                apply(i == 0, i == 1, 0, 0, i == k + 1, 0, 0);
            else
                apply(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL halt_drain cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
        n_vec++;
        if (bus.o_halted !== 1'b1 || bus.o_state !== 3'd4 || bus.o_cycle_count !== 32'(k + DEPTH)) begin
            n_bad++;
            $display("FAIL halt_final halted=%b state=%0d count=%0d need 1/4/%0d",
                     bus.o_halted, bus.o_state, bus.o_cycle_count, k + DEPTH);
        end
    endtask

    task automatic test_halt_vs_stop();
        logic [45:0] o, e;
        for (int i = 0; i < 10; i++) begin
            apply(i == 0 || i == 8, i == 1, 0, i == 5, i == 5, 0, 0);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL halt_vs_stop cyc=%0d got=%h exp=%h", i, o, e); end
            if (i == 7) begin
                n_vec++;
                if (bus.o_state !== 3'd3) begin
                    n_bad++;
                    $display("FAIL halt_beats_stop state=%0d need 3", bus.o_state);
                end
            end
            advance();
        end
        n_vec++;
        if (bus.o_cycle_count !== 32'd0 || bus.o_halted !== 1'b0 || bus.o_state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_in_drain count=%0d halted=%b state=%0d need 0/0/0",
                     bus.o_cycle_count, bus.o_halted, bus.o_state);
        end
    endtask

    task automatic test_saturation();
        logic [45:0] o, e;
        for (int i = 0; i < 26; i++) begin
            apply(i == 0, i == 1, 0, i == 24, 0, 0, 0);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL saturation cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
        n_vec++;
        if (bus4.o_cycle_count !== 4'd15) begin
            n_bad++;
            $display("FAIL saturation_hold count4=%0d need 15", bus4.o_cycle_count);
        end
    endtask

    task automatic test_random();
        logic [45:0] o, e;
        for (int i = 0; i < 400; i++) begin
            apply(i == 0 || $urandom_range(0, 49) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            o = obs_vec(); e = exp_vec(); n_vec++;
            if (o !== e) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, o, e); end
            advance();
        end
    endtask

    initial begin
        i_reset               = 1'b1;
        bus.i_cmd_run         = 1'b0;
        bus.i_cmd_step        = 1'b0;
        bus.i_cmd_stop        = 1'b0;
        bus.i_halt_fetched    = 1'b0;
        bus.i_load_use_hazard = 1'b0;
        bus.i_branch_taken    = 1'b0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_single_step();
        test_run_stop();
        test_hazards();
        test_halt_drain();
        test_halt_vs_stop();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
